pipe_chain: RTL and testbench
=============================

// Module: pipe_chain
// PURPOSE
//  Parametrised elastic pipeline register chain carrying a bundled per-stage payload
//  (pc, ir, operands) between CPU stages.
//  - Adds a valid bit per stage.
//  - Adds a per-stage stall that holds the stage and everything behind it, inserting
//    a bubble ahead.
//  - Adds a per-stage kill for branch/jump flushes.
//  - Adds a ready/valid handshake at both ends.
//  Sits between fetch (input side) and writeback/retire (output side).
// PARAMETERS
//  DEPTH  4   number of pipeline stages, >= 2
//  WIDTH  64  payload bits per stage
//  CNT_W  32  width of performance counters (only with PIPE_PERF_EN)
// PORTS
//  clock        in   1            rising-edge clock
//  reset        in   1            asynchronous, active-low reset
//  in_valid     in   1            producer presents in_data
//  in_data      in   WIDTH        payload entering stage 0
//  in_ready     out  1            stage 0 accepts this cycle
//  stall        in   DEPTH        stall[i]=1: stage i must not advance
//  kill         in   DEPTH        kill[i]=1: discard content of stage i
//  stage_valid  out  DEPTH        registered valid bit per stage
//  stage_data   out  DEPTH*WIDTH  stage i payload at [i*WIDTH +: WIDTH]
//  out_valid    out  1            = stage_valid[DEPTH-1]
//  out_data     out  WIDTH        payload of stage DEPTH-1
//  out_ready    in   1            consumer takes stage DEPTH-1 this cycle
//  perf_retire  out  CNT_W        items handed out (out_valid & out_ready & ~kill/stall)
//  perf_bubble  out  CNT_W        cycles with out_valid=0
//  perf_kill    out  CNT_W        valid entries discarded by kill
// BEHAVIOUR
//  - Reset (reset=0, async): all stage_valid=0, all stage_data=0, perf counters=0.
//    Reset has priority over everything, including mid-transfer.
//  - Effective valid: ev[i] = stage_valid[i] & ~kill[i].
//  - Advance: mv[i] = ev[i] & ~stall[i] & acc[i+1]. Evaluated combinationally,
//    last stage first.
//  - Accept: acc[i] = ~ev[i] | mv[i]; acc[DEPTH] = out_ready.
//  - Handshake outputs: in_ready = acc[0]. Input transfer t_in = in_valid & in_ready.
//  - Per-stage update at the clock edge, in priority order:
//    1. Stage i incoming (i=0: t_in; else mv[i-1]): data <= upstream payload, valid <= 1.
//       An incoming item enters a killed stage normally; kill targets only the resident
//       item.
//    2. Else kill[i], or mv[i] out with nothing in: valid <= 0 (bubble). Data is unchanged.
//    3. Else hold: valid and data unchanged.
//  - Data register is written only on incoming; it never changes otherwise.
//  - Latency: an item entering with no stalls appears at out_valid DEPTH cycles after
//    its t_in cycle.
//  - Throughput: one item per cycle when unstalled.
//  - in_ready is combinationally dependent on stall/kill/out_ready. There is no
//    combinational path from in_valid/in_data to in_ready.
//  - Stall at stage i holds stages 0..i (as they fill). Stage i+1 receives a bubble.
//  - Simultaneous stall[i] and kill[i]: kill wins. The entry is dropped, and stage i
//    may accept new data that cycle.
//  - Simultaneous kill of stages 0..k with in_valid=1: the new item is accepted into
//    stage 0 (the redirected fetch).
//  - out_valid is asserted while the last stage holds an item, even if kill[DEPTH-1]=1.
//    A consumer must qualify with ~kill.
//  - Full chain with out_ready=0 and no kill: in_ready=0. Nothing is lost or overwritten.
// CONFIGURATION
//  - PIPE_PERF_EN defined: the three perf counters increment per rules above and
//    saturate at all-ones. perf_kill adds popcount(stage_valid & kill) per cycle.
//  - PIPE_PERF_EN undefined: perf_* ports remain and are tied to 0. No counter flops
//    are synthesised.
// STRUCTURE
//  - Add to codes.v: PIPE_IF/PIPE_RR/PIPE_ALU/PIPE_MEM stage-index constants and
//    payload field offsets (PC_LSB, IR_LSB).
//  - Sub-module pipe_stage: one valid+data register with load/clear/hold controls.
//    Instantiated DEPTH times via generate.
//  - Control (ev/mv/acc chain) and perf counters live in pipe_chain.
// TESTING
//  - Streaming: DEPTH=4, in_valid=1, data 1,2,3..., out_ready=1, no stall/kill.
//    Item 1 at out on cycle 4, then one per cycle, in_ready always 1.
//  - Back-pressure: out_ready=0 for 6 cycles. After 4 accepts in_ready=0, stage_data
//    holds 4,3,2,1. Release gives 1,2,3,4 in order, no loss or duplicates.
//  - Mid stall: stall[1]=1 for 2 cycles with full stream.
//    - stage 2 sees 2 bubbles, stage 0 and 1 hold.
//    - perf_bubble +2 at output later.
//  - Flush: kill=4'b0011 with in_valid=1, data=0xA0.
//    - stages 0 and 1 drop their entries, stage 0 loads 0xA0, stage 1 becomes invalid.
//    - perf_kill +2.
//  - Kill vs stall: stall[2]=1 and kill[2]=1 on the same cycle. The stage 2 entry is
//    dropped and stage 2 accepts the stage 1 item.
//  - Async reset: assert reset=0 mid-stream between edges. All valid go 0 immediately,
//    and counters clear.

Source files
------------

// File: rtl/pipe_chain_pkg.sv
// Shared definitions for the pipe_chain elastic pipeline: stage indices, payload
// field offsets and the per-stage register command encoding.
package pipe_chain_pkg;

   typedef enum int unsigned {
      PIPE_IF  = 0,
      PIPE_RR  = 1,
      PIPE_ALU = 2,
      PIPE_MEM = 3
   } pipe_stage_idx_e;

   // Payload layout: pc occupies the low word, ir the word above it.
   typedef enum int unsigned {
      PC_LSB = 0,
      IR_LSB = 32
   } payload_lsb_e;

   typedef enum logic [1:0] {
      STAGE_HOLD,
      STAGE_LOAD,
      STAGE_CLEAR
   } stage_cmd_e;

   function automatic stage_cmd_e stage_cmd(input logic load, input logic clear);
      if (load) begin
         return STAGE_LOAD;
      end else if (clear) begin
         return STAGE_CLEAR;
      end
      return STAGE_HOLD;
   endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// One pipeline slot: a valid bit plus payload register. Load beats clear beats
// hold; the payload only ever changes on a load.
module pipe_chain_stage
   import pipe_chain_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] load_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   stage_cmd_e cmd;

   assign cmd = stage_cmd(load, clear);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         case (cmd)
            STAGE_LOAD: begin
               valid <= 1'b1;
               data  <= load_data;
            end
            STAGE_CLEAR: valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pipe_chain.sv
// Elastic pipeline register chain with per-stage stall/kill and ready/valid ends.
// Define PIPE_PERF_EN to build the saturating retire/bubble/kill counters.
module pipe_chain
   import pipe_chain_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   parameter int CNT_W = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   input  logic [DEPTH-1:0]       stall,
   input  logic [DEPTH-1:0]       kill,
   output logic [DEPTH-1:0]       stage_valid,
   output logic [DEPTH*WIDTH-1:0] stage_data,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   input  logic                   out_ready,
   output logic [CNT_W-1:0]       perf_retire,
   output logic [CNT_W-1:0]       perf_bubble,
   output logic [CNT_W-1:0]       perf_kill
);

   logic [DEPTH-1:0] ev;
   logic [DEPTH-1:0] mv;
   logic [DEPTH-1:0] load;
   logic [DEPTH-1:0] clear;
   logic             t_in;
   logic [WIDTH-1:0] up_data [DEPTH];

   // Accept ripples from the consumer back toward stage 0; a killed slot counts as empty.
   always_comb begin
      logic acc;
      acc = out_ready;
      ev  = '0;
      mv  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         ev[i] = stage_valid[i] & ~kill[i];
         mv[i] = ev[i] & ~stall[i] & acc;
         acc   = ~ev[i] | mv[i];
      end
      in_ready = acc;
   end

   assign t_in = in_valid & in_ready;

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign load[g]    = t_in;
         assign up_data[g] = in_data;
      end else begin : g_body
         assign load[g]    = mv[g-1];
         assign up_data[g] = stage_data[(g-1)*WIDTH +: WIDTH];
      end

      assign clear[g] = kill[g] | mv[g];

      pipe_chain_stage #(
         .WIDTH(WIDTH)
      ) u_stage (
         .clock    (clock),
         .reset    (reset),
         .load     (load[g]),
         .clear    (clear[g]),
         .load_data(up_data[g]),
         .valid    (stage_valid[g]),
         .data     (stage_data[g*WIDTH +: WIDTH])
      );
   end

   assign out_valid = stage_valid[DEPTH-1];
   assign out_data  = stage_data[(DEPTH-1)*WIDTH +: WIDTH];

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] retire_q;
   logic [CNT_W-1:0] bubble_q;
   logic [CNT_W-1:0] kill_q;
   logic [CNT_W:0]   kill_sum;

   // Extra top bit catches overflow so the kill counter can clamp at all-ones.
   always_comb begin
      kill_sum = {1'b0, kill_q};
      for (int i = 0; i < DEPTH; i++) begin
         kill_sum = kill_sum + (CNT_W+1)'(stage_valid[i] & kill[i]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         retire_q <= '0;
         bubble_q <= '0;
         kill_q   <= '0;
      end else begin
         if (mv[DEPTH-1] && (retire_q != '1)) begin
            retire_q <= retire_q + CNT_W'(1);
         end
         if (!out_valid && (bubble_q != '1)) begin
            bubble_q <= bubble_q + CNT_W'(1);
         end
         kill_q <= kill_sum[CNT_W] ? '1 : kill_sum[CNT_W-1:0];
      end
   end

   assign perf_retire = retire_q;
   assign perf_bubble = bubble_q;
   assign perf_kill   = kill_q;
`else
   assign perf_retire = '0;
   assign perf_bubble = '0;
   assign perf_kill   = '0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Scoreboard bench for pipe_chain (DEPTH=4): directed streaming, back-pressure,
// stall, flush, kill-vs-stall and async reset. Honours PIPE_PERF_EN for counter checks.
module tb_pipe_chain;

   localparam int DEPTH = 4;
   localparam int WIDTH = 64;
   localparam int CNT_W = 32;

   logic                   clock = 1'b0;
   logic                   reset = 1'b0;
   logic                   in_valid = 1'b0;
   logic [WIDTH-1:0]       in_data = '0;
   logic                   in_ready;
   logic [DEPTH-1:0]       stall = '0;
   logic [DEPTH-1:0]       kill = '0;
   logic [DEPTH-1:0]       stage_valid;
   logic [DEPTH*WIDTH-1:0] stage_data;
   logic                   out_valid;
   logic [WIDTH-1:0]       out_data;
   logic                   out_ready = 1'b0;
   logic [CNT_W-1:0]       perf_retire;
   logic [CNT_W-1:0]       perf_bubble;
   logic [CNT_W-1:0]       perf_kill;

   int               checks = 0;
   int               failures = 0;
   int               pops = 0;
   logic [WIDTH-1:0] sb [$];

   always #5 clock = ~clock;

   pipe_chain #(
      .DEPTH(DEPTH),
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .stall      (stall),
      .kill       (kill),
      .stage_valid(stage_valid),
      .stage_data (stage_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .perf_retire(perf_retire),
      .perf_bubble(perf_bubble),
      .perf_kill  (perf_kill)
   );

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] slot(input int i);
      return stage_data[i*WIDTH +: WIDTH];
   endfunction

   // Drive one cycle; an accepted item's payload becomes the next expected output.
   task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] kl,
                                 input logic ordy, output logic took);
      in_valid  = v;
      in_data   = d;
      stall     = st;
      kill      = kl;
      out_ready = ordy;
      @(negedge clock);
      took = v & in_ready;
      if (took) sb.push_back(d);
      @(posedge clock);
      #1;
   endtask

   // Monitor: every genuine hand-off must match the oldest outstanding item.
   always @(negedge clock) begin
      if (reset && out_valid && out_ready && !kill[DEPTH-1] && !stall[DEPTH-1]) begin
         pops++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sb_unexpected: got %0h expected no output", out_data);
         end else begin
            check_output("sb_out", out_data, sb.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic             took;
      logic [WIDTH-1:0] d;
      logic [CNT_W-1:0] snap;
      logic             exp_rdy [6];

      exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      repeat (2) @(posedge clock);
      #1;
      check_output("rst_valid", 64'(stage_valid), 64'd0);
      check_output("rst_data", 64'(|stage_data), 64'd0);
      check_output("rst_out_valid", 64'(out_valid), 64'd0);
      check_output("rst_in_ready", 64'(in_ready), 64'd1);
      check_output("rst_perf", 64'(perf_retire | perf_bubble | perf_kill), 64'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;

      $display("[TB] streaming");
      for (int k = 1; k <= 8; k++) begin
         apply_stimulus(1'b1, 64'(k), '0, '0, 1'b1, took);
         check_output("stream_in_ready", 64'(took), 64'd1);
         if (k == 3) check_output("latency_early", 64'(out_valid), 64'd0);
         if (k == 4) begin
            check_output("latency_valid", 64'(out_valid), 64'd1);
            check_output("latency_data", out_data, 64'd1);
         end
      end
      repeat (5) apply_stimulus(1'b0, '0, '0, '0, 1'b1, took);
      check_output("stream_drained", 64'(sb.size()), 64'd0);

      $display("[TB] back-pressure");
      d = 64'd11;
      for (int c = 0; c < 6; c++) begin
         apply_stimulus(1'b1, d, '0, '0, 1'b0, took);
         check_output("bp_in_ready", 64'(took), 64'(exp_rdy[c]));
         if (took) d++;
      end
      check_output("bp_full", 64'(stage_valid), 64'hF);
      check_output("bp_s0", slot(0), 64'd14);
      check_output("bp_s1", slot(1), 64'd13);
      check_output("bp_s2", slot(2), 64'd12);
      check_output("bp_s3", slot(3), 64'd11);
      repeat (5) apply_stimulus(1'b0, '0, '0, '0, 1'b1, took);
      check_output("bp_drained", 64'(sb.size()), 64'd0);

      $display("[TB] mid stall");
      d = 64'd21;
      snap = '0;
      for (int c = 1; c <= 10; c++) begin
         apply_stimulus(1'b1, d, (c == 5 || c == 6) ? 4'b0010 : 4'b0000, '0, 1'b1, took);
         if (c == 5 || c == 6) check_output("stall_in_ready", 64'(took), 64'd0);
         if (took) d++;
         if (c == 5) check_output("stall_valid_a", 64'(stage_valid), 64'b1011);
         if (c == 6) begin
            check_output("stall_valid_b", 64'(stage_valid), 64'b0011);
            check_output("stall_s0", slot(0), 64'd24);
            check_output("stall_s1", slot(1), 64'd23);
            snap = perf_bubble;
         end
         if (c == 8) begin
`ifdef PIPE_PERF_EN
            check_output("stall_bubbles", 64'(perf_bubble - snap), 64'd2);
`else
            check_output("stall_bubbles_off", 64'(perf_bubble), 64'd0);
`endif
         end
      end
      repeat (5) apply_stimulus(1'b0, '0, '0, '0, 1'b1, took);
      check_output("stall_drained", 64'(sb.size()), 64'd0);

      $display("[TB] flush");
      for (int k = 31; k <= 34; k++) apply_stimulus(1'b1, 64'(k), '0, '0, 1'b1, took);
      void'(sb.pop_back());
      void'(sb.pop_back());
      snap = perf_kill;
      apply_stimulus(1'b1, 64'hA0, '0, 4'b0011, 1'b0, took);
      check_output("flush_in_ready", 64'(took), 64'd1);
      check_output("flush_valid", 64'(stage_valid), 64'b1101);
      check_output("flush_s0", slot(0), 64'hA0);
      check_output("flush_s1_kept", slot(1), 64'd33);
      check_output("flush_s3", slot(3), 64'd31);
`ifdef PIPE_PERF_EN
      check_output("flush_perf_kill", 64'(perf_kill - snap), 64'd2);
`else
      check_output("flush_perf_kill_off", 64'(perf_kill), 64'd0);
`endif

      $display("[TB] kill vs stall");
      apply_stimulus(1'b1, 64'hB0, '0, '0, 1'b0, took);
      check_output("ks_in_ready", 64'(took), 64'd1);
      sb.delete(1);
      snap = perf_kill;
      apply_stimulus(1'b0, '0, 4'b0100, 4'b0100, 1'b0, took);
      check_output("ks_valid", 64'(stage_valid), 64'b1110);
      check_output("ks_s1", slot(1), 64'hB0);
      check_output("ks_s2", slot(2), 64'hA0);
      check_output("ks_s3", slot(3), 64'd31);
`ifdef PIPE_PERF_EN
      check_output("ks_perf_kill", 64'(perf_kill - snap), 64'd1);
`endif
      repeat (5) apply_stimulus(1'b0, '0, '0, '0, 1'b1, took);
      check_output("ks_drained", 64'(sb.size()), 64'd0);
`ifdef PIPE_PERF_EN
      check_output("perf_retire", 64'(perf_retire), 64'(pops));
`else
      check_output("perf_retire_off", 64'(perf_retire), 64'd0);
`endif

      $display("[TB] async reset");
      for (int k = 41; k <= 43; k++) apply_stimulus(1'b1, 64'(k), '0, '0, 1'b1, took);
      #2;
      reset = 1'b0;
      #1;
      check_output("ar_valid", 64'(stage_valid), 64'd0);
      check_output("ar_out_valid", 64'(out_valid), 64'd0);
      check_output("ar_data", 64'(|stage_data), 64'd0);
      check_output("ar_perf", 64'(perf_retire | perf_bubble | perf_kill), 64'd0);
      sb.delete();
      in_valid = 1'b0;
      #10;
      reset = 1'b1;
      @(posedge clock);
      #1;
      for (int k = 51; k <= 52; k++) apply_stimulus(1'b1, 64'(k), '0, '0, 1'b1, took);
      repeat (5) apply_stimulus(1'b0, '0, '0, '0, 1'b1, took);
      check_output("ar_recover_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
